// File: rtl/regfile_sync_2r1w.sv
// regfile_sync_2r1w: 2-read / 1-write register file with synchronous writes,
// combinational reads, optional hard-wired zero register, same-cycle write
// forwarding and a one-register-per-cycle clear sweep after reset.
// Optional feature macro: REGFILE_BYTE_WRITE_EN (adds wr_be byte enables).
module regfile_sync_2r1w #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   rd_addr1,
    input  logic [ADDR_W-1:0]   rd_addr2,
    output logic [DATA_W-1:0]   rd_data1,
    output logic [DATA_W-1:0]   rd_data2,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
`ifdef REGFILE_BYTE_WRITE_EN
    input  logic [DATA_W/8-1:0] wr_be,
`endif
    output logic                ready
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_nxt;

    logic [DATA_W-1:0] regs [DEPTH];

    logic              wr_fire;
    logic [DATA_W-1:0] wr_word;

`ifdef REGFILE_BYTE_WRITE_EN
    // Replace only the enabled bytes of the stored word.
    function automatic logic [DATA_W-1:0] byte_merge(
        input logic [DATA_W-1:0]   old_word,
        input logic [DATA_W-1:0]   new_word,
        input logic [DATA_W/8-1:0] be
    );
        logic [DATA_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < DATA_W/8; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

    assign wr_word = byte_merge(regs[wr_addr], wr_data, wr_be);
`else
    assign wr_word = wr_data;
`endif

    assign ready = (state == RUN);

    // Writes are accepted only once the sweep is done; writes to r0 vanish
    // when the zero register is hard-wired.
    assign wr_fire = ready && wr_en && !(ZERO_REG && (wr_addr == '0));

    // Control state: reset restarts the sweep from register 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Sweep sequencing: step idx each cycle, leave INIT after the last register.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        if (state == INIT) begin
            idx_nxt = idx + IDX_ONE;
            if (idx == IDX_LAST) begin
                state_nxt = RUN;
            end
        end
    end

    // Storage array: cleared one entry per cycle in INIT, written in RUN.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            regs[idx] <= '0;
        end else if (wr_fire) begin
            regs[wr_addr] <= wr_word;
        end
    end

    // Read port 1: forwarding first, zero register overrides, blank until ready.
    always_comb begin
        rd_data1 = regs[rd_addr1];
        if (BYPASS && wr_fire && (wr_addr == rd_addr1)) begin
            rd_data1 = wr_word;
        end
        if (ZERO_REG && (rd_addr1 == '0)) begin
            rd_data1 = '0;
        end
        if (!ready) begin
            rd_data1 = '0;
        end
    end

    // Read port 2: same rules as port 1, evaluated independently.
    always_comb begin
        rd_data2 = regs[rd_addr2];
        if (BYPASS && wr_fire && (wr_addr == rd_addr2)) begin
            rd_data2 = wr_word;
        end
        if (ZERO_REG && (rd_addr2 == '0)) begin
            rd_data2 = '0;
        end
        if (!ready) begin
            rd_data2 = '0;
        end
    end

endmodule
